if_pc_sequencer: RTL and testbench
==================================

// Module: if_pc_sequencer
// PURPOSE
//  IF-stage PC sequencer; the consumer of the ID controller's redirect controls (npc select, branch,
//  delay-slot, eret). Holds the fetch PC and handshakes fetches with instruction memory.
//  Applies ID-resolved redirects after the delay slot is fetched, latching the target when the slot fetch
//  is still outstanding. Tags each fetch with BD and address-error flags for CP0.
// PARAMETERS
//  RESET_PC    32'h0000_3000  PC after reset
//  EXC_VECTOR  32'h0000_4180  exception entry PC
//  IMEM_BASE   32'h0000_3000  lowest legal fetch address
//  IMEM_LIMIT  32'h0000_6ffc  highest legal fetch address
// PORTS
//  clk                 in   1   clock; all state updates on the rising edge
//  reset               in   1   synchronous reset, active-high
//  if_stall            in   1   hazard unit holds IF/ID
//  imem_ready          in   1   instruction word for if_pc is valid this cycle
//  id_accept           in   1   instruction in ID advances to EX this cycle
//  id_branch           in   1   ID instruction is a branch/jump/eret (controller branch_instruction)
//  id_has_delay_slot   in   1   ID instruction has a delay slot
//  id_taken            in   1   selective comparer result; true for unconditional jumps
//  id_npc_ctrl         in   1   0: j/jal 26-bit index; 1: PC-relative offset
//  id_npc_addr_select  in   1   1: register target (jr/jalr) or EPC (eret)
//  id_eret             in   1   ID instruction is eret
//  id_pc               in   32  PC of the ID instruction
//  id_imm32            in   32  sign-extended 16-bit offset
//  id_index26          in   26  j/jal instr_index
//  id_reg_target       in   32  forwarded rs value
//  cp0_epc             in   32  EPC from CP0
//  exc_req             in   1   exception/interrupt commit from a later stage
//  if_pc               out  32  current fetch address
//  if_advance          out  1   fetch completes, IF/ID captures (imem_ready & ~if_stall & ~reset)
//  if_bd               out  1   captured instruction is a delay slot
//  if_adel             out  1   if_pc misaligned or outside [IMEM_BASE,IMEM_LIMIT]
//  if_nullify          out  1   captured slot is to be squashed (see CONFIGURATION)
// BEHAVIOUR
//  - Target: npc_addr_select ? (eret ? cp0_epc : id_reg_target) : npc_ctrl ? id_pc+4+(id_imm32<<2)
//    : {id_pc[31:28],id_index26,2'b00}. 32-bit modulo, no overflow detection. next = id_taken ? target : pc+4.
//  - Redirect event R = id_accept & id_branch & ~exc_req.
//  - States RUN, PENDING; target_q[31:0] holds the latched target.
//  - RUN: R & has_delay_slot & if_advance -> pc<=next, if_bd=1, stay RUN.
//    R & has_delay_slot & ~if_advance -> target_q<=next, go PENDING, pc holds.
//    R & ~has_delay_slot -> pc<=next, if_advance forced 0 this cycle (fetched word discarded).
//    no R & if_advance -> pc<=pc+4. Otherwise pc holds.
//  - PENDING: if_bd=1. if_advance -> pc<=target_q, go RUN. A new R in PENDING cannot occur
//    (slot not yet in ID); no response to it is required.
//  - exc_req, highest priority, any state: pc<=EXC_VECTOR, state<=RUN, pending target dropped.
//    if_advance forced 0 that cycle.
//  - Stall with branch in ID and no id_accept: no redirect; pc and state hold.
//  - if_adel is combinational on if_pc. The fetch still advances; the flag travels with the instruction.
//  - Reset (overrides all): pc=RESET_PC, state=RUN, target_q=0, if_advance=0, if_bd=0, if_nullify=0.
//    Reset mid-PENDING discards the pending target.
//  - Latency: redirect visible on if_pc one cycle after the slot is captured.
// CONFIGURATION
//  BRANCH_LIKELY_EN defined: adds input id_branch_likely (1). R with id_branch_likely & ~id_taken
//    asserts if_nullify with the slot capture, in RUN or, latched, in PENDING.
//  Undefined: port absent, if_nullify tied 0.
// TESTING
//  - reset 3 cycles, imem_ready=1 -> if_pc 0x3000,0x3004,0x3008; if_bd=0, if_adel=0.
//  - beq at 0x3000 taken, imm32=3, slot ready -> slot 0x3004 captured with if_bd=1; next if_pc=0x3010.
//  - jr at 0x3008, reg=0x3100, imem_ready=0 for 2 cycles -> PENDING, if_pc holds 0x300c;
//    then ready -> slot captured with if_bd=1, if_pc=0x3100.
//  - exc_req while PENDING -> if_pc=0x4180, state RUN, if_advance=0, latched target never used.
//  - jr reg=0x3002 -> if_adel=1 at 0x3002; jr reg=0x7000 -> if_adel=1.
//  - BRANCH_LIKELY_EN: likely branch not taken -> slot if_nullify=1, if_pc=slot+4; taken -> if_nullify=0.

Source files
------------

// File: rtl/if_pc_sequencer.sv
// if_pc_sequencer: IF-stage fetch PC sequencer; applies ID redirects after the delay slot.
// Optional feature macro: BRANCH_LIKELY_EN (adds id_branch_likely, drives if_nullify).
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   if_stall            hazard unit holds IF/ID
//   imem_ready          instruction word for if_pc is valid this cycle
//   id_accept           ID instruction advances to EX this cycle
//   id_branch           ID instruction is a branch/jump/eret
//   id_has_delay_slot   ID instruction has a delay slot
//   id_taken            branch outcome (1 for unconditional jumps)
//   id_npc_ctrl         0: 26-bit index target, 1: PC-relative target
//   id_npc_addr_select  1: register target (jr/jalr) or EPC (eret)
//   id_eret             ID instruction is eret
//   id_pc               PC of the ID instruction
//   id_imm32            sign-extended branch offset (words)
//   id_index26          j/jal instr_index
//   id_reg_target       forwarded rs value
//   cp0_epc             EPC from CP0
//   exc_req             exception/interrupt commit, highest priority
//   id_branch_likely    (BRANCH_LIKELY_EN only) ID branch is a branch-likely
//   if_pc               current fetch address
//   if_advance          fetch completes and IF/ID captures the word
//   if_bd               captured instruction is a delay slot
//   if_adel             if_pc misaligned or outside instruction memory
//   if_nullify          captured delay slot must be squashed
module if_pc_sequencer #(
   parameter logic [31:0] RESET_PC   = 32'h0000_3000,
   parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
   parameter logic [31:0] IMEM_BASE  = 32'h0000_3000,
   parameter logic [31:0] IMEM_LIMIT = 32'h0000_6ffc
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_stall,
   input  logic        imem_ready,
   input  logic        id_accept,
   input  logic        id_branch,
   input  logic        id_has_delay_slot,
   input  logic        id_taken,
   input  logic        id_npc_ctrl,
   input  logic        id_npc_addr_select,
   input  logic        id_eret,
   input  logic [31:0] id_pc,
   input  logic [31:0] id_imm32,
   input  logic [25:0] id_index26,
   input  logic [31:0] id_reg_target,
   input  logic [31:0] cp0_epc,
   input  logic        exc_req,
`ifdef BRANCH_LIKELY_EN
   input  logic        id_branch_likely,
`endif
   output logic [31:0] if_pc,
   output logic        if_advance,
   output logic        if_bd,
   output logic        if_adel,
   output logic        if_nullify
);

   typedef enum logic {
      S_RUN,
      S_PENDING
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_pc;
   logic [31:0] w_pc_nxt;
   logic [31:0] r_target;
   logic [31:0] w_target_nxt;
   logic        r_nul;
   logic        w_nul_nxt;

   logic [31:0] w_pc_inc;
   logic [31:0] w_br_target;
   logic [31:0] w_next;
   logic        w_redirect;
   logic        w_fetch_ok;
   logic        w_likely_nt;

   assign w_pc_inc = r_pc + 32'd4;

   // Redirect target from the ID controller's npc selects.
   always_comb begin
      w_br_target = {id_pc[31:28], id_index26, 2'b00};
      if (id_npc_addr_select) begin
         w_br_target = id_eret ? cp0_epc : id_reg_target;
      end else if (id_npc_ctrl) begin
         w_br_target = id_pc + 32'd4 + (id_imm32 << 2);
      end
   end

   assign w_next     = id_taken ? w_br_target : w_pc_inc;
   assign w_redirect = id_accept & id_branch & ~exc_req;
   assign w_fetch_ok = imem_ready & ~if_stall & ~reset;

`ifdef BRANCH_LIKELY_EN
   assign w_likely_nt = id_branch_likely & ~id_taken;
`else
   assign w_likely_nt = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_RUN;
         r_pc     <= RESET_PC;
         r_target <= 32'd0;
         r_nul    <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_pc     <= w_pc_nxt;
         r_target <= w_target_nxt;
         r_nul    <= w_nul_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_pc_nxt     = r_pc;
      w_target_nxt = r_target;
      w_nul_nxt    = r_nul;
      if_advance   = 1'b0;
      if_bd        = 1'b0;
      if_nullify   = 1'b0;
      if (reset) begin
         // registers reload in the sequential block; outputs stay quiet
         w_state_nxt = S_RUN;
      end else if (exc_req) begin
         // exception wins: any outstanding redirect is discarded
         w_state_nxt  = S_RUN;
         w_pc_nxt     = EXC_VECTOR;
         w_target_nxt = 32'd0;
         w_nul_nxt    = 1'b0;
      end else begin
         unique case (r_state)
            S_RUN: begin
               if_advance = w_fetch_ok;
               if (w_redirect && id_has_delay_slot) begin
                  if (w_fetch_ok) begin
                     // slot captured now; jump right behind it
                     w_pc_nxt   = w_next;
                     if_bd      = 1'b1;
                     if_nullify = w_likely_nt;
                  end else begin
                     // slot still outstanding; hold target until it lands
                     w_target_nxt = w_next;
                     w_nul_nxt    = w_likely_nt;
                     w_state_nxt  = S_PENDING;
                  end
               end else if (w_redirect) begin
                  // no delay slot: the word at if_pc is not executed
                  if_advance = 1'b0;
                  w_pc_nxt   = w_next;
               end else if (w_fetch_ok) begin
                  w_pc_nxt = w_pc_inc;
               end
            end
            S_PENDING: begin
               if_bd      = 1'b1;
               if_advance = w_fetch_ok;
               if_nullify = r_nul & w_fetch_ok;
               if (w_fetch_ok) begin
                  w_pc_nxt    = r_target;
                  w_nul_nxt   = 1'b0;
                  w_state_nxt = S_RUN;
               end
            end
            default: begin
               w_state_nxt = S_RUN;
            end
         endcase
      end
   end

   assign if_pc   = r_pc;
   assign if_adel = (r_pc[1:0] != 2'b00) ||
                    (r_pc < IMEM_BASE) ||
                    (r_pc > IMEM_LIMIT);

endmodule

// File: tb/tb_if_pc_sequencer.sv
// tb_if_pc_sequencer: directed stimulus for if_pc_sequencer with a
// per-cycle reference model and hand-computed literal checkpoints.
module tb_if_pc_sequencer;

   localparam logic [31:0] RST_PC = 32'h0000_3000;
   localparam logic [31:0] EXC_PC = 32'h0000_4180;
   localparam logic [31:0] LO     = 32'h0000_3000;
   localparam logic [31:0] HI     = 32'h0000_6ffc;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_stall;
   logic        imem_ready;
   logic        id_accept;
   logic        id_branch;
   logic        id_has_delay_slot;
   logic        id_taken;
   logic        id_npc_ctrl;
   logic        id_npc_addr_select;
   logic        id_eret;
   logic [31:0] id_pc;
   logic [31:0] id_imm32;
   logic [25:0] id_index26;
   logic [31:0] id_reg_target;
   logic [31:0] cp0_epc;
   logic        exc_req;
`ifdef BRANCH_LIKELY_EN
   logic        id_branch_likely;
`endif
   logic [31:0] if_pc;
   logic        if_advance;
   logic        if_bd;
   logic        if_adel;
   logic        if_nullify;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   if_pc_sequencer dut (
      .clk                (clk),
      .reset              (reset),
      .if_stall           (if_stall),
      .imem_ready         (imem_ready),
      .id_accept          (id_accept),
      .id_branch          (id_branch),
      .id_has_delay_slot  (id_has_delay_slot),
      .id_taken           (id_taken),
      .id_npc_ctrl        (id_npc_ctrl),
      .id_npc_addr_select (id_npc_addr_select),
      .id_eret            (id_eret),
      .id_pc              (id_pc),
      .id_imm32           (id_imm32),
      .id_index26         (id_index26),
      .id_reg_target      (id_reg_target),
      .cp0_epc            (cp0_epc),
      .exc_req            (exc_req),
`ifdef BRANCH_LIKELY_EN
      .id_branch_likely   (id_branch_likely),
`endif
      .if_pc              (if_pc),
      .if_advance         (if_advance),
      .if_bd              (if_bd),
      .if_adel            (if_adel),
      .if_nullify         (if_nullify)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Reference model: architectural fetch PC plus an optional
   // "target owed after the slot" record.
   logic [31:0] m_pc   = RST_PC;
   bit          m_owe  = 1'b0;
   logic [31:0] m_dest = 32'd0;
   bit          m_kill = 1'b0;
   logic [31:0] n_pc   = RST_PC;
   bit          n_owe  = 1'b0;
   logic [31:0] n_dest = 32'd0;
   bit          n_kill = 1'b0;
   bit          started = 1'b0;

   always @(negedge clk) begin
      bit          e_adv, e_bd, e_nul, e_adel, got, redir, lnt;
      logic [31:0] dest, nxt;
      e_adv = 0; e_bd = 0; e_nul = 0;
      n_pc = m_pc; n_owe = m_owe; n_dest = m_dest; n_kill = m_kill;
      got   = imem_ready && !if_stall;
      redir = id_accept && id_branch && !exc_req;
`ifdef BRANCH_LIKELY_EN
      lnt = id_branch_likely && !id_taken;
`else
      lnt = 0;
`endif
      if (id_npc_addr_select)
         dest = id_eret ? cp0_epc : id_reg_target;
      else if (id_npc_ctrl)
         dest = id_pc + 4 + id_imm32 * 4;
      else
         dest = {id_pc[31:28], id_index26, 2'b00};
      nxt = id_taken ? dest : m_pc + 4;
      if (reset) begin
         n_pc = RST_PC; n_owe = 0; n_dest = 0; n_kill = 0;
      end else if (exc_req) begin
         n_pc = EXC_PC; n_owe = 0; n_dest = 0; n_kill = 0;
      end else if (m_owe) begin
         e_bd = 1; e_adv = got; e_nul = m_kill && got;
         if (got) begin n_pc = m_dest; n_owe = 0; n_kill = 0; end
      end else if (redir && id_has_delay_slot) begin
         if (got) begin
            e_adv = 1; e_bd = 1; e_nul = lnt; n_pc = nxt;
         end else begin
            n_owe = 1; n_dest = nxt; n_kill = lnt;
         end
      end else if (redir) begin
         n_pc = nxt;
      end else if (got) begin
         e_adv = 1; n_pc = m_pc + 4;
      end
      e_adel = (m_pc % 4 != 0) || (m_pc < LO) || (m_pc > HI);
      if (started) begin
         chk("model_pc", if_pc, m_pc);
         chk("model_adv", {31'd0, if_advance}, {31'd0, e_adv});
         chk("model_bd", {31'd0, if_bd}, {31'd0, e_bd});
         chk("model_nul", {31'd0, if_nullify}, {31'd0, e_nul});
         chk("model_adel", {31'd0, if_adel}, {31'd0, e_adel});
      end
   end

   always @(posedge clk) begin
      m_pc = n_pc; m_owe = n_owe; m_dest = n_dest; m_kill = n_kill;
      started = 1'b1;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      id_accept = 0; id_branch = 0; id_has_delay_slot = 0;
      id_taken = 0; id_npc_ctrl = 0; id_npc_addr_select = 0;
      id_eret = 0; exc_req = 0; if_stall = 0;
`ifdef BRANCH_LIKELY_EN
      id_branch_likely = 0;
`endif
   endtask

   // branch in ID, accepted this cycle
   task automatic br(input logic ds, input logic tk, input logic ctl,
                     input logic sel, input logic [31:0] pc,
                     input logic [31:0] imm, input logic [31:0] rt);
      id_accept = 1; id_branch = 1; id_has_delay_slot = ds;
      id_taken = tk; id_npc_ctrl = ctl; id_npc_addr_select = sel;
      id_eret = 0; id_pc = pc; id_imm32 = imm; id_reg_target = rt;
   endtask

   task automatic do_reset();
      reset = 1;
      step();
      reset = 0;
   endtask

   initial begin
      reset = 1; imem_ready = 1;
      id_pc = 0; id_imm32 = 0; id_index26 = 0;
      id_reg_target = 0; cp0_epc = 0;
      idle();
      repeat (3) step();
      reset = 0;
      chk("rst_pc", if_pc, 32'h3000);
      #1 chk("rst_adel", {31'd0, if_adel}, 32'd0);
      chk("rst_bd", {31'd0, if_bd}, 32'd0);
      step();
      chk("seq_pc1", if_pc, 32'h3004);
      // beq at 0x3000 taken, imm 3 -> 0x3010
      br(1, 1, 1, 0, 32'h3000, 32'd3, 0);
      #1 chk("beq_bd", {31'd0, if_bd}, 32'd1);
      step(); idle();
      chk("beq_pc", if_pc, 32'h3010);

      // jr at 0x3008 while slot not ready
      do_reset();
      step(); step(); step();
      chk("seq_pc3", if_pc, 32'h300c);
      br(1, 1, 0, 1, 32'h3008, 0, 32'h3100);
      imem_ready = 0;
      step(); idle();
      chk("pend_hold", if_pc, 32'h300c);
      #1 chk("pend_bd", {31'd0, if_bd}, 32'd1);
      step();
      imem_ready = 1;
      #1 chk("pend_adv", {31'd0, if_advance}, 32'd1);
      step();
      chk("pend_pc", if_pc, 32'h3100);

      // exception while a target is owed
      br(1, 1, 0, 1, 32'h30fc, 0, 32'h3200);
      imem_ready = 0;
      step(); idle();
      imem_ready = 1; exc_req = 1;
      #1 chk("exc_adv", {31'd0, if_advance}, 32'd0);
      step(); idle();
      chk("exc_pc", if_pc, 32'h4180);
      step();
      chk("exc_drop", if_pc, 32'h4184);

      // address-error flags
      br(1, 1, 0, 1, 32'h4180, 0, 32'h3002);
      step(); idle();
      chk("adel_pc", if_pc, 32'h3002);
      #1 chk("adel_mis", {31'd0, if_adel}, 32'd1);
      br(1, 1, 0, 1, 32'h2ffe, 0, 32'h6ffc);
      step(); idle();
      #1 chk("adel_top", {31'd0, if_adel}, 32'd0);
      step();
      chk("adel_pc2", if_pc, 32'h7000);
      #1 chk("adel_hi", {31'd0, if_adel}, 32'd1);
      br(1, 1, 0, 1, 32'h6ffc, 0, 32'h2ffc);
      step(); idle();
      #1 chk("adel_lo", {31'd0, if_adel}, 32'd1);

      // j with index, backward beq, not-taken beq
      br(1, 1, 0, 0, 32'h3010, 0, 0);
      id_index26 = 26'h0000c10;
      step(); idle();
      chk("j_pc", if_pc, 32'h3040);
      br(1, 1, 1, 0, 32'h3100, 32'hffff_fffc, 0);
      step(); idle();
      chk("bback_pc", if_pc, 32'h30f4);
      step();
      br(1, 0, 1, 0, 32'h30f4, 32'd20, 0);
      step(); idle();
      chk("bnt_pc", if_pc, 32'h30fc);

      // eret: no slot, fetched word dropped
      br(0, 1, 0, 1, 32'h30f8, 0, 0);
      id_eret = 1; cp0_epc = 32'h3500;
      #1 chk("eret_adv", {31'd0, if_advance}, 32'd0);
      step(); idle();
      chk("eret_pc", if_pc, 32'h3500);

      // stall with branch in ID and no accept
      if_stall = 1; id_branch = 1;
      step(); idle();
      chk("stall_pc", if_pc, 32'h3500);

      // reset mid-pending discards the target
      br(1, 1, 0, 1, 32'h34fc, 0, 32'h5000);
      imem_ready = 0;
      step(); idle();
      imem_ready = 1;
      do_reset();
      chk("rstp_pc", if_pc, 32'h3000);
      step();
      chk("rstp_pc2", if_pc, 32'h3004);

`ifdef BRANCH_LIKELY_EN
      br(1, 0, 1, 0, 32'h3000, 32'd8, 0);
      id_branch_likely = 1;
      #1 chk("bl_nul", {31'd0, if_nullify}, 32'd1);
      step(); idle();
      chk("bl_pc", if_pc, 32'h3008);
      br(1, 1, 1, 0, 32'h3004, 32'd8, 0);
      id_branch_likely = 1;
      #1 chk("bl_tk", {31'd0, if_nullify}, 32'd0);
      step(); idle();
      br(1, 0, 1, 0, 32'h3024, 32'd8, 0);
      id_branch_likely = 1; imem_ready = 0;
      step(); idle();
      imem_ready = 1;
      #1 chk("bl_pend", {31'd0, if_nullify}, 32'd1);
      step();
`endif
      repeat (2) step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
